// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 device-to-host frame receiver with input synchronizers,
// clock glitch filter, odd-parity/stop checking and an inter-bit timeout.  Rev 1.0
`default_nettype none

module ps2_rx_frame #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       i_sclr,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_err,
  output logic       o_busy
);

  localparam int unsigned TW = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          fclk_q, fclk_d;
  logic [7:0]    fcnt_q, fcnt_d;
  state_t        state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    sr_q, sr_d;
  logic          par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          bit_event;
  logic          bit_val;
  logic          expire;

  always_comb begin
    clk_s1_d = i_ps2_clk;
    clk_s2_d = clk_s1_q;
    dat_s1_d = i_ps2_dat;
    dat_s2_d = dat_s1_q;

    // Filtered clock follows only a run of FILTER_LEN disagreeing samples.
    fclk_d = fclk_q;
    fcnt_d = 8'd0;
    if (clk_s2_q != fclk_q) begin
      if (fcnt_q == 8'(FILTER_LEN - 1)) begin
        fclk_d = clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
  end

  assign bit_event = fclk_q & ~fclk_d;
  assign bit_val   = dat_s2_q;
  // A simultaneous bit event always beats the timeout.
  assign expire    = (state_q != IDLE) && !bit_event && (tcnt_q == TW'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sr_d    = sr_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    tcnt_d  = (state_q == IDLE || bit_event) ? '0 : tcnt_q + 1'b1;

    if (expire) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else if (bit_event) begin
      unique case (state_q)
        IDLE: begin
          if (!bit_val) begin
            state_d = DATA;
            bcnt_d  = 3'd0;
          end
        end
        DATA: begin
          sr_d   = {bit_val, sr_q[7:1]};
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = bit_val;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (bit_val && ((^sr_q) ^ par_q)) begin
            data_d  = sr_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      fclk_q   <= 1'b1;
      fcnt_q   <= 8'd0;
      state_q  <= IDLE;
      bcnt_q   <= 3'd0;
      sr_q     <= 8'd0;
      par_q    <= 1'b0;
      tcnt_q   <= '0;
      data_q   <= 8'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      clk_s1_q <= clk_s1_d;
      clk_s2_q <= clk_s2_d;
      dat_s1_q <= dat_s1_d;
      dat_s2_q <= dat_s2_d;
      fclk_q   <= fclk_d;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      sr_q     <= sr_d;
      par_q    <= par_d;
      tcnt_q   <= tcnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_err   = err_q;
  assign o_busy  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx_frame.sv
// tb_ps2_rx_frame: directed table, corner-case sequences and random frames
// checked against a frame-level reference model.  Rev 1.0
`default_nettype none

module tb_ps2_rx_frame;

  localparam int unsigned FL = 8;
  localparam int unsigned TO = 2000;

  logic       clk = 1'b0;
  logic       i_sclr = 1'b1;
  logic       i_ps2_clk = 1'b1;
  logic       i_ps2_dat = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_err, o_busy;

  ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .i_sclr    (i_sclr),
    .i_ps2_clk (i_ps2_clk),
    .i_ps2_dat (i_ps2_dat),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_err     (o_err),
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int n_rule   = 0;
  logic busy_seen = 1'b0;
  logic prev_v = 1'b0, prev_e = 1'b0;

  // Pulse counters and pulse-shape rules, sampled away from the active edge.
  always @(negedge clk) begin
    if (o_valid) n_valid++;
    if (o_err) n_err++;
    if (o_busy) busy_seen = 1'b1;
    if ((o_valid && o_err) || (o_valid && prev_v) || (o_err && prev_e)) n_rule++;
    prev_v = o_valid;
    prev_e = o_err;
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    n_valid = 0; n_err = 0; busy_seen = 1'b0;
  endtask

  // One PS/2 bit: data set while clock high, 40 clk low then 40 clk high.
  task automatic send_bit(input logic b);
    i_ps2_dat = b;
    tick(20);
    i_ps2_clk = 1'b0;
    tick(40);
    i_ps2_clk = 1'b1;
    tick(20);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stp);
    i_ps2_dat = 1'b1;
    tick(30);
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0);
  endfunction

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stp;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[5];
  logic [7:0] model_data;

  initial begin
    // Table: good 0x1C, bad parity on 0x1C (data held), good 0xF0,
    // bad stop (data held), good 0xA5.
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 0, 1, 8'h1C};
    vecs[2] = '{8'hF0, 1'b1, 1'b1, 1, 0, 8'hF0};
    vecs[3] = '{8'h3C, 1'b1, 1'b0, 0, 1, 8'hF0};
    vecs[4] = '{8'hA5, 1'b1, 1'b1, 1, 0, 8'hA5};

    tick(4);
    i_sclr = 1'b0;
    tick(2);
    check("reset_data", int'(o_data), 0);
    check("reset_valid", int'(o_valid), 0);
    check("reset_err", int'(o_err), 0);
    check("reset_busy", int'(o_busy), 0);

    for (int k = 0; k < 5; k++) begin
      clear_counts();
      send_frame(vecs[k].data, vecs[k].par, vecs[k].stp);
      check($sformatf("tbl%0d_valid", k), n_valid, vecs[k].exp_valid);
      check($sformatf("tbl%0d_err", k), n_err, vecs[k].exp_err);
      check($sformatf("tbl%0d_data", k), int'(o_data), int'(vecs[k].exp_data));
      check($sformatf("tbl%0d_busy", k), int'(o_busy), 0);
    end

    // Short clock glitch must be filtered out and add no bit.
    clear_counts();
    i_ps2_clk = 1'b0; tick(3); i_ps2_clk = 1'b1; tick(30);
    check("glitch_busy", int'(busy_seen), 0);
    send_frame(8'hF0, 1'b1, 1'b1);
    check("glitch_valid", n_valid, 1);
    check("glitch_err", n_err, 0);
    check("glitch_data", int'(o_data), 8'hF0);

    // Truncated frame aborted by timeout, then a clean frame.
    clear_counts();
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    check("to_busy_open", int'(o_busy), 1);
    tick(TO + 10);
    check("to_err", n_err, 1);
    check("to_valid", n_valid, 0);
    check("to_busy", int'(o_busy), 0);
    clear_counts();
    send_frame(8'hF0, 1'b1, 1'b1);
    check("to_next_valid", n_valid, 1);
    check("to_next_data", int'(o_data), 8'hF0);

    // Reset mid-frame abandons the frame silently.
    clear_counts();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    i_sclr = 1'b1; tick(1); i_sclr = 1'b0;
    tick(TO + 50);
    check("rst_valid", n_valid, 0);
    check("rst_err", n_err, 0);
    check("rst_data", int'(o_data), 0);
    check("rst_busy", int'(o_busy), 0);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("rst_next_valid", n_valid, 1);
    check("rst_next_data", int'(o_data), 8'h1C);

    // Falling edge with data high in IDLE is not a start bit.
    clear_counts();
    send_bit(1'b1);
    tick(30);
    check("spur_busy", int'(busy_seen), 0);
    check("spur_valid", n_valid, 0);
    check("spur_err", n_err, 0);
    check("spur_data", int'(o_data), 8'h1C);

    // Random frames against the frame-level model.
    model_data = 8'h1C;
    for (int k = 0; k < 20; k++) begin
      logic [7:0] d;
      logic p, s, good;
      d = 8'($urandom);
      p = ($urandom_range(0, 3) == 0) ? ~odd_par(d) : odd_par(d);
      s = ($urandom_range(0, 5) != 0);
      good = s && (p == odd_par(d));
      if (good) model_data = d;
      clear_counts();
      send_frame(d, p, s);
      check($sformatf("rnd%0d_valid", k), n_valid, good ? 1 : 0);
      check($sformatf("rnd%0d_err", k), n_err, good ? 0 : 1);
      check($sformatf("rnd%0d_data", k), int'(o_data), int'(model_data));
    end

    check("pulse_rules", n_rule, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
